// File: rtl/pong_pkg.sv
// Shared pong definitions: playfield geometry, direction and paddle state
// encodings, and the saturating paddle move used by the paddle channels.
package pong_pkg;

  localparam int SCREEN_HEIGHT = 480;
  localparam int PADDLE_HEIGHT = 50;
  localparam int BALL_SIZE     = 4;
  localparam int MAX_POS       = SCREEN_HEIGHT - PADDLE_HEIGHT;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_t;

  // Move pos by speed in direction dir, saturating at 0 and max_pos.
  // The downward sum is formed at 11 bits so it cannot wrap.
  function automatic logic [9:0] clamp_move(input logic [9:0] pos,
                                            input dir_t       dir,
                                            input logic [9:0] speed,
                                            input logic [9:0] max_pos);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = {1'b0, pos} + {1'b0, speed};
    res = pos;
    case (dir)
      UP:      res = (pos < speed) ? 10'd0 : (pos - speed);
      DOWN:    res = (sum > {1'b0, max_pos}) ? max_pos : sum[9:0];
      default: res = pos;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Bus between the frame/button side and paddle_ctrl.
// Handshake: none -- vsync and buttons are level inputs sampled every clk;
// paddle positions are registered levels that change only 2 clk after a
// vsync falling edge and hold otherwise. p1_state/p2_state expose the
// per-player velocity FSMs for observation.
// With PADDLE_AI_EN defined the bus also carries ball_vpos and ai_enable.
interface paddle_ctrl_if;
  import pong_pkg::*;

  logic       vsync;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic [9:0] paddle1_next;
  logic [9:0] paddle2_next;
  state_t     p1_state;
  state_t     p2_state;

`ifdef PADDLE_AI_EN
  logic [9:0] ball_vpos;
  logic       ai_enable;

  modport master (
    output vsync, p1_up, p1_down, p2_up, p2_down, ball_vpos, ai_enable,
    input  paddle1_next, paddle2_next, p1_state, p2_state
  );

  modport slave (
    input  vsync, p1_up, p1_down, p2_up, p2_down, ball_vpos, ai_enable,
    output paddle1_next, paddle2_next, p1_state, p2_state
  );
`else
  modport master (
    output vsync, p1_up, p1_down, p2_up, p2_down,
    input  paddle1_next, paddle2_next, p1_state, p2_state
  );

  modport slave (
    input  vsync, p1_up, p1_down, p2_up, p2_down,
    output paddle1_next, paddle2_next, p1_state, p2_state
  );
`endif

endinterface

// File: rtl/paddle_channel.sv
// One player's paddle: 2-flop synchronisers and debouncers for up/down,
// a per-frame IDLE/SLOW/FAST velocity FSM and the clamped position register.
// i_override replaces the button-driven move with i_override_pos on a tick
// and parks the FSM in IDLE (used for an externally driven paddle).
module paddle_channel
  import pong_pkg::*;
#(
  parameter int MAX_P           = 430,
  parameter int SLOW_SPEED      = 2,
  parameter int FAST_SPEED      = 6,
  parameter int ACCEL_FRAMES    = 8,
  parameter int DEBOUNCE_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_override,
  input  logic [9:0] i_override_pos,
  output logic [9:0] o_pos,
  output state_t     o_state
);

  localparam int         CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int         AW        = $clog2(ACCEL_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] SLOW_V    = 10'(SLOW_SPEED);
  localparam logic [9:0] FAST_V    = 10'(FAST_SPEED);
  localparam logic [9:0] MAX_V     = 10'(MAX_P);
  localparam logic [9:0] RESET_POS = 10'(MAX_P / 2);

  // bit 0 = up, bit 1 = down
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_stable;
  logic [CW-1:0] r_cnt [2];

  state_t        r_state;
  dir_t          r_last_dir;
  logic [AW-1:0] r_count;
  logic [9:0]    r_pos;
  dir_t          w_dir;

  // Synchronise raw buttons and accept a new level only after it has
  // differed from the stable level for DEBOUNCE_CYCLES consecutive clks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int b = 0; b < 2; b++) r_cnt[b] <= '0;
    end else begin
      r_sync1 <= {i_down, i_up};
      r_sync2 <= r_sync1;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_stable[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_LAST) begin
          r_stable[b] <= r_sync2[b];
          r_cnt[b]    <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
    end
  end

  // Decode debounced buttons; both pressed cancels out.
  always_comb begin
    w_dir = NONE;
    if (r_stable[0] && !r_stable[1]) w_dir = UP;
    else if (r_stable[1] && !r_stable[0]) w_dir = DOWN;
  end

  // Velocity FSM and position register, advanced once per frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_dir <= NONE;
      r_count    <= '0;
      r_pos      <= RESET_POS;
    end else if (i_tick) begin
      if (i_override) begin
        r_state    <= IDLE;
        r_last_dir <= NONE;
        r_count    <= '0;
        r_pos      <= i_override_pos;
      end else if (w_dir == NONE) begin
        r_state <= IDLE;
        r_count <= '0;
      end else if (r_state == IDLE || w_dir != r_last_dir) begin
        r_state    <= SLOW;
        r_last_dir <= w_dir;
        r_count    <= '0;
        r_pos      <= clamp_move(r_pos, w_dir, SLOW_V, MAX_V);
      end else if (r_state == SLOW) begin
        r_count <= r_count + AW'(1);
        r_pos   <= clamp_move(r_pos, w_dir, SLOW_V, MAX_V);
        // The switch is decided here but the move on this frame stays slow.
        if (int'(r_count) + 1 >= ACCEL_FRAMES - 1) r_state <= FAST;
      end else begin
        r_pos <= clamp_move(r_pos, w_dir, FAST_V, MAX_V);
      end
    end
  end

  assign o_pos   = r_pos;
  assign o_state = r_state;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position producer for the pong core. Detects the vsync falling
// edge, runs one paddle_channel per player and updates both positions on
// the clk after the registered tick, so they are stable across the core's
// vsync rising-edge sample.
// Optional feature macro: PADDLE_AI_EN (adds ball_vpos/ai_enable and an
// AI that steers player 2 toward the ball).
module paddle_ctrl #(
  parameter int SCREEN_HEIGHT   = pong_pkg::SCREEN_HEIGHT,
  parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
  parameter int SLOW_SPEED      = 2,
  parameter int FAST_SPEED      = 6,
  parameter int ACCEL_FRAMES    = 8,
  parameter int DEBOUNCE_CYCLES = 25000
`ifdef PADDLE_AI_EN
  ,
  parameter int AI_SPEED        = 3
`endif
) (
  input  logic          clk,
  input  logic          reset,
  paddle_ctrl_if.slave  bus
);
  import pong_pkg::*;

  localparam int LP_MAX = SCREEN_HEIGHT - PADDLE_HEIGHT;

  logic       r_vsync;
  logic       r_tick;
  logic [9:0] w_pos1;
  logic [9:0] w_pos2;
  state_t     w_state1;
  state_t     w_state2;
  logic       w_override;
  logic [9:0] w_ai_pos;

  // Falling-edge detect on vsync, registered so updates land 2 clk after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_vsync <= bus.vsync;
      r_tick  <= r_vsync & ~bus.vsync;
    end
  end

`ifdef PADDLE_AI_EN
  localparam logic [9:0] MAX_V = 10'(LP_MAX);
  localparam logic [9:0] AI_V  = 10'(AI_SPEED);

  logic signed [10:0] w_tgt_s;
  logic [9:0]         w_target;

  // AI target: ball centre line minus half a paddle, clamped to the field,
  // then a bounded step toward it that snaps when within AI_SPEED.
  always_comb begin
    w_tgt_s  = $signed({1'b0, bus.ball_vpos}) + $signed(11'(BALL_SIZE / 2))
             - $signed(11'(PADDLE_HEIGHT / 2));
    w_target = w_tgt_s[9:0];
    if (w_tgt_s < 0) w_target = 10'd0;
    else if (w_tgt_s > $signed({1'b0, MAX_V})) w_target = MAX_V;
    w_ai_pos = w_pos2;
    if (w_target >= w_pos2) begin
      if (w_target - w_pos2 <= AI_V) w_ai_pos = w_target;
      else w_ai_pos = w_pos2 + AI_V;
    end else begin
      if (w_pos2 - w_target <= AI_V) w_ai_pos = w_target;
      else w_ai_pos = w_pos2 - AI_V;
    end
  end

  assign w_override = bus.ai_enable;
`else
  assign w_override = 1'b0;
  assign w_ai_pos   = '0;
`endif

  paddle_channel #(
    .MAX_P          (LP_MAX),
    .SLOW_SPEED     (SLOW_SPEED),
    .FAST_SPEED     (FAST_SPEED),
    .ACCEL_FRAMES   (ACCEL_FRAMES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk           (clk),
    .reset         (reset),
    .i_tick        (r_tick),
    .i_up          (bus.p1_up),
    .i_down        (bus.p1_down),
    .i_override    (1'b0),
    .i_override_pos(10'd0),
    .o_pos         (w_pos1),
    .o_state       (w_state1)
  );

  paddle_channel #(
    .MAX_P          (LP_MAX),
    .SLOW_SPEED     (SLOW_SPEED),
    .FAST_SPEED     (FAST_SPEED),
    .ACCEL_FRAMES   (ACCEL_FRAMES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch2 (
    .clk           (clk),
    .reset         (reset),
    .i_tick        (r_tick),
    .i_up          (bus.p2_up),
    .i_down        (bus.p2_down),
    .i_override    (w_override),
    .i_override_pos(w_ai_pos),
    .o_pos         (w_pos2),
    .o_state       (w_state2)
  );

  assign bus.paddle1_next = w_pos1;
  assign bus.paddle2_next = w_pos2;
  assign bus.p1_state     = w_state1;
  assign bus.p2_state     = w_state2;

endmodule
